// File: rtl/mipi_video_tx_scheduler.sv
// DSI video-mode TX scheduler: emits VSS/HSS sync packets and RGB888 long packets per line.
// Optional macro SYNC_PULSE_EN selects sync-pulse mode (VSE/HSE end packets after each sync).
module mipi_video_tx_scheduler #(
    parameter int         H_ACT   = 1080,
    parameter int         V_SA    = 2,
    parameter int         V_BP    = 8,
    parameter int         V_ACT   = 1920,
    parameter int         V_FP    = 8,
    parameter int         H_TOTAL = 1200,
    parameter logic [1:0] VC      = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_prog_empty,
    output logic        fifo_ren,
    input  logic        host_tx_cmd_ack,
    input  logic        host_tx_payload_en,
    input  logic        host_tx_payload_en_last,
    output logic        host_tx_cmd_req,
    output logic [1:0]  host_tx_cmd_vc,
    output logic [5:0]  host_tx_cmd_data_type,
    output logic [15:0] host_tx_cmd_byte_count,
    output logic        host_tx_hs_mode,
    output logic [31:0] host_tx_payload,
    output logic [15:0] underflow_cnt
);

    localparam int LINES = V_SA + V_BP + V_ACT + V_FP;
    localparam int WORDS = (H_ACT * 3 + 3) / 4;
    localparam int LW    = (LINES > 2) ? $clog2(LINES) : 1;
    localparam int TW    = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
    localparam int WW    = $clog2(WORDS + 1);

    localparam logic [LW-1:0] LINE_LAST  = LW'(LINES - 1);
    localparam logic [LW-1:0] ACT_FIRST  = LW'(V_SA + V_BP);
    localparam logic [LW-1:0] ACT_LAST   = LW'(V_SA + V_BP + V_ACT - 1);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(H_TOTAL - 1);
    localparam logic [WW-1:0] WORD_LAST  = WW'(WORDS - 1);
    localparam logic [15:0]   PIX_WC     = 16'(H_ACT * 3);

    localparam logic [5:0] DT_VSS = 6'h01;
    localparam logic [5:0] DT_HSS = 6'h21;
    localparam logic [5:0] DT_RGB = 6'h3E;
`ifdef SYNC_PULSE_EN
    localparam logic [5:0] DT_VSE = 6'h11;
    localparam logic [5:0] DT_HSE = 6'h31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SYNC_END,
        ST_PIX_CMD,
        ST_PIX_DATA,
        ST_LINE_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PIX_CMD,
        ST_PIX_DATA,
        ST_LINE_WAIT
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [TW-1:0] line_tmr_q, line_tmr_d;
    logic [WW-1:0] word_cnt_q, word_cnt_d;
    logic          req_q, req_d;
    logic [5:0]    dtype_q, dtype_d;
    logic [15:0]   wc_q, wc_d;
    logic          hs_mode_q, hs_mode_d;
    logic [15:0]   underflow_q, underflow_d;

    logic line_start;
    logic sync_done;
    logic line_active;
    logic tmr_zero;
    logic rd_en;

    assign line_active = (line_cnt_q >= ACT_FIRST) && (line_cnt_q <= ACT_LAST);
    assign tmr_zero    = (line_tmr_q == '0);
    // The word cap keeps the FIFO from being over-read if the host misses its last flag.
    assign rd_en       = (state_q == ST_PIX_DATA) && host_tx_payload_en && (word_cnt_q <= WORD_LAST);

    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        line_tmr_d  = line_tmr_q;
        word_cnt_d  = word_cnt_q;
        req_d       = req_q;
        dtype_d     = dtype_q;
        wc_d        = wc_q;
        hs_mode_d   = hs_mode_q;
        underflow_d = underflow_q;
        line_start  = 1'b0;
        sync_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_SYNC;
                    line_cnt_d = '0;
                    hs_mode_d  = 1'b1;
                    req_d      = 1'b1;
                    dtype_d    = DT_VSS;
                    wc_d       = '0;
                    line_start = 1'b1;
                end
            end
            ST_SYNC: begin
                if (host_tx_cmd_ack) begin
`ifdef SYNC_PULSE_EN
                    state_d = ST_SYNC_END;
                    req_d   = 1'b0;
                    dtype_d = (line_cnt_q == '0) ? DT_VSE : DT_HSE;
`else
                    sync_done = 1'b1;
`endif
                end
            end
`ifdef SYNC_PULSE_EN
            // req drops for one cycle between the sync and its end packet.
            ST_SYNC_END: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (host_tx_cmd_ack) begin
                    sync_done = 1'b1;
                end
            end
`endif
            ST_PIX_CMD: begin
                if (req_q) begin
                    if (host_tx_cmd_ack) begin
                        req_d      = 1'b0;
                        state_d    = ST_PIX_DATA;
                        word_cnt_d = '0;
                    end
                end else if (!fifo_prog_empty) begin
                    req_d = 1'b1;
                end else if (tmr_zero) begin
                    if (underflow_q != 16'hFFFF) begin
                        underflow_d = underflow_q + 16'd1;
                    end
                    state_d = ST_LINE_WAIT;
                end
            end
            ST_PIX_DATA: begin
                if (rd_en) begin
                    word_cnt_d = word_cnt_q + WW'(1);
                    if (host_tx_payload_en_last || (word_cnt_q == WORD_LAST)) begin
                        state_d = ST_LINE_WAIT;
                    end
                end
            end
            ST_LINE_WAIT: begin
                if (tmr_zero) begin
                    line_start = 1'b1;
                    wc_d       = '0;
                    if (line_cnt_q == LINE_LAST) begin
                        line_cnt_d = '0;
                        if (enable) begin
                            state_d = ST_SYNC;
                            req_d   = 1'b1;
                            dtype_d = DT_VSS;
                        end else begin
                            state_d   = ST_IDLE;
                            req_d     = 1'b0;
                            dtype_d   = '0;
                            hs_mode_d = 1'b0;
                        end
                    end else begin
                        line_cnt_d = line_cnt_q + LW'(1);
                        state_d    = ST_SYNC;
                        req_d      = 1'b1;
                        dtype_d    = DT_HSS;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (sync_done) begin
            req_d = 1'b0;
            if (line_active) begin
                state_d = ST_PIX_CMD;
                dtype_d = DT_RGB;
                wc_d    = PIX_WC;
            end else begin
                state_d = ST_LINE_WAIT;
            end
        end

        // Timer saturates at zero so an overrunning packet ends its line as soon as it completes.
        if (line_start) begin
            line_tmr_d = TMR_RELOAD;
        end else if (!tmr_zero) begin
            line_tmr_d = line_tmr_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            line_cnt_q  <= '0;
            line_tmr_q  <= '0;
            word_cnt_q  <= '0;
            req_q       <= 1'b0;
            dtype_q     <= '0;
            wc_q        <= '0;
            hs_mode_q   <= 1'b0;
            underflow_q <= '0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            line_tmr_q  <= line_tmr_d;
            word_cnt_q  <= word_cnt_d;
            req_q       <= req_d;
            dtype_q     <= dtype_d;
            wc_q        <= wc_d;
            hs_mode_q   <= hs_mode_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo_ren               = rd_en;
    assign host_tx_cmd_req        = req_q;
    assign host_tx_cmd_vc         = VC;
    assign host_tx_cmd_data_type  = dtype_q;
    assign host_tx_cmd_byte_count = wc_q;
    assign host_tx_hs_mode        = hs_mode_q;
    assign host_tx_payload        = fifo_dout;
    assign underflow_cnt          = underflow_q;

endmodule
